// File: rtl/rfile_mp.sv
// Multi-port register file with byte-lane merging writes, byte-wise collision
// resolution and registered reads. Optional write-before-read forwarding: RFILE_BYPASS_EN.
module rfile_mp #(
  parameter int XLEN     = 64,
  parameter int XWDT     = 6,
  parameter int XN       = 64,
  parameter int NRD      = 3,
  parameter int NWR      = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NRD-1:0]                 rd_en,
  input  logic [NRD-1:0][XWDT-1:0]       rd_addr,
  output logic [NRD-1:0][XLEN-1:0]       rd_data,
  input  logic [NWR-1:0]                 wr_en,
  input  logic [NWR-1:0][XWDT-1:0]       wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]       wr_data,
  input  logic [NWR-1:0][1:0]            wr_size,
  input  logic [NWR-1:0][3:0]            wr_pos,
  output logic [NWR-1:0]                 wr_err
);

  localparam int NB = XLEN / 8;

  // Handshake: rd_en/wr_en are single-cycle qualifiers sampled on every rising
  // edge; there is no backpressure, results appear exactly one edge later.
  logic [XLEN-1:0]           regs_q [XN];
  logic [XLEN-1:0]           regs_d [XN];
  logic [NRD-1:0][XLEN-1:0]  rd_data_q, rd_data_d;
  logic [NWR-1:0]            wr_err_q, wr_err_d;
  logic [NWR-1:0]            wr_ok, zero_hit, bad;
  int                        lane_b [NWR];
  int                        lane_l [NWR];

  always_comb begin : geom
    wr_ok    = '0;
    wr_err_d = '0;
    zero_hit = '0;
    bad      = '0;
    for (int p = 0; p < NWR; p++) begin
      lane_b[p]   = 1 << wr_size[p];
      lane_l[p]   = int'(wr_pos[p]) * lane_b[p];
      zero_hit[p] = (ZERO_REG != 0) && (wr_addr[p] == '0);
      bad[p]      = ((lane_l[p] + lane_b[p]) * 8 > XLEN) ||
                    ((XN < (1 << XWDT)) && (int'(wr_addr[p]) >= XN));
      wr_ok[p]    = wr_en[p] && !zero_hit[p] && !bad[p];
      wr_err_d[p] = wr_en[p] && !zero_hit[p] && bad[p];
    end
  end

  // Ascending port order lets the highest port overwrite shared bytes last.
  always_comb begin : merge
    regs_d = regs_q;
    for (int p = 0; p < NWR; p++) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_ok[p] && (k >= lane_l[p]) && (k < lane_l[p] + lane_b[p])) begin
          regs_d[wr_addr[p]][8*k +: 8] = wr_data[p][8*(k - lane_l[p]) +: 8];
        end
      end
    end
  end

  always_comb begin : rd_sel
    rd_data_d = rd_data_q;
    for (int r = 0; r < NRD; r++) begin
      if (rd_en[r]) begin
        if ((int'(rd_addr[r]) >= XN) || ((ZERO_REG != 0) && (rd_addr[r] == '0))) begin
          rd_data_d[r] = '0;
        end else begin
`ifdef RFILE_BYPASS_EN
          rd_data_d[r] = regs_d[rd_addr[r]];
`else
          rd_data_d[r] = regs_q[rd_addr[r]];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < XN; i++) begin
        regs_q[i] <= '0;
      end
      rd_data_q <= '0;
      wr_err_q  <= '0;
    end else begin
      regs_q    <= regs_d;
      rd_data_q <= rd_data_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign rd_data = rd_data_q;
  assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_rfile_mp.sv
// Directed scoreboard bench for rfile_mp: stimulus pushes expected read data and
// error strobes into queues, a negedge monitor pops and compares them.
module tb_rfile_mp;

  localparam int XLEN = 64;
  localparam int XWDT = 6;
  localparam int NRD  = 3;
  localparam int NWR  = 3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NRD-1:0]            rd_en;
  logic [NRD-1:0][XWDT-1:0]  rd_addr;
  logic [NRD-1:0][XLEN-1:0]  rd_data;
  logic [NWR-1:0]            wr_en;
  logic [NWR-1:0][XWDT-1:0]  wr_addr;
  logic [NWR-1:0][XLEN-1:0]  wr_data;
  logic [NWR-1:0][1:0]       wr_size;
  logic [NWR-1:0][3:0]       wr_pos;
  logic [NWR-1:0]            wr_err;

  logic [XLEN-1:0] exp_q[$];
  logic [0:0]      err_q[$];
  logic [XLEN-1:0] last_rd [NRD];
  logic [NRD-1:0]  rd_pend;
  logic [NWR-1:0]  wr_pend;
  int checks = 0;
  int errors = 0;

  rfile_mp dut (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_size (wr_size),
    .wr_pos  (wr_pos),
    .wr_err  (wr_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    rd_en = '0; rd_addr = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_size = '0; wr_pos = '0;
  endtask

  task automatic wr(input int p, input logic [XWDT-1:0] a, input logic [XLEN-1:0] d,
                    input logic [1:0] sz, input logic [3:0] pos, input logic e);
    wr_en[p] = 1'b1; wr_addr[p] = a; wr_data[p] = d; wr_size[p] = sz; wr_pos[p] = pos;
    err_q.push_back(e);
  endtask

  task automatic rd(input int r, input logic [XWDT-1:0] a, input logic [XLEN-1:0] e);
    rd_en[r] = 1'b1; rd_addr[r] = a;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rd_en = '0;
    wr_en = '0;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= '0;
      wr_pend <= '0;
    end else begin
      rd_pend <= rd_en;
      wr_pend <= wr_en;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int r = 0; r < NRD; r++) last_rd[r] = '0;
    end else begin
      for (int r = 0; r < NRD; r++) begin
        if (rd_pend[r]) begin
          if (exp_q.size() == 0) begin
            chk("rd_underflow", 64'd1, 64'd0);
          end else begin
            last_rd[r] = exp_q.pop_front();
            chk($sformatf("rd_data[%0d]", r), rd_data[r], last_rd[r]);
          end
        end else begin
          chk($sformatf("rd_hold[%0d]", r), rd_data[r], last_rd[r]);
        end
      end
      for (int p = 0; p < NWR; p++) begin
        if (wr_pend[p]) begin
          if (err_q.size() == 0) begin
            chk("err_underflow", 64'd1, 64'd0);
          end else begin
            chk($sformatf("wr_err[%0d]", p), {63'd0, wr_err[p]}, {63'd0, err_q.pop_front()});
          end
        end else begin
          chk($sformatf("wr_err_idle[%0d]", p), {63'd0, wr_err[p]}, 64'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd0", rd_data[0], '0);
    chk("reset_rd1", rd_data[1], '0);
    chk("reset_rd2", rd_data[2], '0);
    chk("reset_err", {61'd0, wr_err}, '0);
    rst = 1'b0;
    step();

    // asynchronous reset while x5 holds data
    wr(0, 6'd5, 64'hDEAD, 2'd3, 4'd0, 1'b0); step();
    rd(1, 6'd5, 64'hDEAD); step();
    step();
    rst = 1'b1;
    #1;
    chk("async_rst_rd1", rd_data[1], '0);
    chk("async_rst_err", {61'd0, wr_err}, '0);
    step();
    rst = 1'b0;
    step();
    rd(1, 6'd5, 64'h0); step();

    // partial byte merge
    wr(0, 6'd3, 64'h1111_2222_3333_4444, 2'd3, 4'd0, 1'b0); step();
    wr(1, 6'd3, 64'hAB, 2'd0, 4'd2, 1'b0); step();
    rd(0, 6'd3, 64'h1111_2222_33AB_4444); step();

    // same-cycle collisions
    wr(0, 6'd7, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 4'd0, 1'b0);
    wr(2, 6'd7, 64'h1234, 2'd1, 4'd1, 1'b0); step();
    rd(2, 6'd7, 64'hFFFF_FFFF_1234_FFFF); step();
    wr(0, 6'd8, 64'hAAAA, 2'd1, 4'd0, 1'b0);
    wr(1, 6'd8, 64'h11, 2'd0, 4'd0, 1'b0);
    wr(2, 6'd8, 64'h22, 2'd0, 4'd0, 1'b0); step();
    rd(0, 6'd8, 64'hAA22); step();

    // illegal field geometry
    wr(0, 6'd10, 64'h0102_0304_0506_0708, 2'd3, 4'd0, 1'b0); step();
    wr(1, 6'd10, 64'hDEAD_BEEF, 2'd2, 4'd2, 1'b1);
    wr(2, 6'd10, 64'h5555_5555_5555_5555, 2'd3, 4'd1, 1'b1); step();
    rd(1, 6'd10, 64'h0102_0304_0506_0708); step();
    wr(1, 6'd10, 64'hCAFE_BABE, 2'd2, 4'd1, 1'b0); step();
    rd(1, 6'd10, 64'hCAFE_BABE_0506_0708);
    wr(2, 6'd11, 64'h77, 2'd0, 4'd8, 1'b1); step();

    // zero register
    wr(0, 6'd0, 64'h55, 2'd3, 4'd0, 1'b0); step();
    rd(0, 6'd0, 64'h0); step();

    // read and write of the same register at one edge
    wr(0, 6'd9, 64'h10, 2'd3, 4'd0, 1'b0); step();
    wr(0, 6'd9, 64'h20, 2'd3, 4'd0, 1'b0);
`ifdef RFILE_BYPASS_EN
    rd(2, 6'd9, 64'h20);
`else
    rd(2, 6'd9, 64'h10);
`endif
    step();
    rd(2, 6'd9, 64'h20); step();

    repeat (3) step();
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("err_q_drained", 64'(err_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rfile_mp.md
Name: rfile_mp

Overview:
Parametrised multi-port integer register file; successor to the core's single-enable rfile.
- Per-port write enables.
- Byte-lane partial writes that merge into, rather than overwrite, the existing register contents.
- Deterministic byte-wise resolution of same-cycle write collisions.
- Registered read ports and an illegal-write error strobe.
- Sits between decode (read addresses) and writeback (write ports) in the core pipeline.

Parameters:
- XLEN, 64: register width in bits; must be a multiple of 8.
- XWDT, 6: register address width.
- XN, 64: number of registers; XN <= 2**XWDT.
- NRD, 3: number of read ports.
- NWR, 3: number of write ports.
- ZERO_REG, 1: 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  NRD  per-port read enable.
- rd_addr  in  NRD x XWDT  read addresses.
- rd_data  out  NRD x XLEN  registered read data.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR x XWDT  write addresses.
- wr_data  in  NWR x XLEN  write data; the field is taken from the low bits.
- wr_size  in  NWR x 2  field size: 0 = byte, 1 = half, 2 = word, 3 = dword.
- wr_pos  in  NWR x 4  field index, in units of the field size.
- wr_err  out  NWR  one-cycle strobe: that port's write was rejected.

Behaviour:
- Reset:
  - rst high clears all XN registers, all rd_data and all wr_err to 0 immediately, without waiting for clk.
  - While rst is high, all writes and reads are ignored.
  - On the first rising edge after rst falls, normal operation resumes.
- Field geometry per write port:
  - B = 1 << wr_size bytes.
  - Lane offset L = wr_pos * B bytes.
  - Bytes L .. L+B-1 of the register take bytes 0 .. B-1 of wr_data.
  - All other bytes of the register are preserved (read-modify-write).
  - Byte offsets and L are computed in at least 8 bits, so the product never wraps.
- Illegal writes: a write with wr_en=1 is rejected when any of the following holds:
  - (L+B)*8 > XLEN.
  - wr_addr >= XN.
  - A rejected write modifies nothing, and wr_err[p] is 1 in the cycle after the request.
  - When XN = 2**XWDT, the address check never fires and needs no logic.
- Zero register:
  - With ZERO_REG=1, a write to address 0 is silently dropped and wr_err stays 0.
  - A read of address 0 returns 0.
- Collisions:
  - Several enabled ports that target the same register in one cycle merge byte-wise.
  - For every byte written by more than one port, the highest port index wins.
  - Bytes written by exactly one port take that port's data.
- Reads:
  - When rd_en[r]=1 at edge N, rd_data[r] after edge N shows register rd_addr[r] (latency 1).
  - When rd_en[r]=0, rd_data[r] holds its previous value.
  - A read of an address >= XN returns 0 and raises no error.
- Read during write to the same register at edge N: see Optional Feature.
- No simulation $write output is produced.

Optional Feature:
- Macro: RFILE_BYPASS_EN.
- Defined: read data captured at edge N includes all writes accepted at edge N. The merged byte result, including collision resolution, is forwarded to the read port (write-before-read).
- Undefined: read data captured at edge N shows the register contents before the edge N writes (read-before-write). The new value is visible from edge N+1.
- Error, zero-register and reset rules are identical with and without the macro.

Test Plan:
- Reset then read: assert rst mid-simulation with x5=0xDEAD, read port 1 addr 5 -> rd_data[1]=0 with no clk edge; wr_err=0.
- Partial merge: write x3=0x1111_2222_3333_4444 (size 3, pos 0), then size 0, pos 2, data 0xAB -> read x3 = 0x1111_2222_33AB_4444.
- Collision:
  - Stimulus, same cycle to x7 (previously 0): port 0 writes size 3, pos 0, data 0xFFFF_FFFF_FFFF_FFFF; port 2 writes size 1, pos 1, data 0x1234.
  - Required: x7 = 0xFFFF_FFFF_1234_FFFF.
- Illegal write: size 2, pos 2 on XLEN=64 -> wr_err[p]=1 for one cycle and the target register is unchanged. Size 2, pos 1 -> accepted, wr_err=0.
- Zero register (ZERO_REG=1): write x0=0x55 -> read x0 returns 0 and wr_err=0.
- Read/write same edge: x9=0x10, write x9=0x20 and read x9 at edge N.
  - With RFILE_BYPASS_EN: rd_data=0x20.
  - Without RFILE_BYPASS_EN: rd_data=0x10, then 0x20 on the next read.
